// File: rtl/vec_mem_burst_unit.sv
// Sequences one scalar or I-element vector load/store into a burst of byte-wide
// accesses on a single-port synchronous RAM. Optional bounds check: VMEM_BOUNDS_CHECK_EN.
module vec_mem_burst_unit #(
  parameter int I         = 20,
  parameter int L         = 8,
  parameter int A         = 32,
  parameter int RD_LAT    = 1,
  parameter int MEM_DEPTH = 4096
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           req_valid_i,
  output logic           req_ready_o,
  input  logic           op_vec_i,
  input  logic           op_we_i,
  input  logic [A-1:0]   addr_i,
  input  logic [I*L-1:0] wdata_v_i,
  input  logic [L-1:0]   wdata_s_i,
  output logic [A-1:0]   mem_addr_o,
  output logic [L-1:0]   mem_wdata_o,
  output logic           mem_we_o,
  input  logic [L-1:0]   mem_rdata_i,
  output logic [I*L-1:0] rdata_v_o,
  output logic [L-1:0]   rdata_s_o,
  output logic           done_o,
  output logic           busy_o,
  output logic           err_o
);

  localparam int CW = $clog2(I) + 1;

`ifdef VMEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic            op_vec_q, op_vec_d;
  logic [I*L-1:0]  wdata_q, wdata_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cap_idx_q, cap_idx_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [A-1:0]    mem_addr_q, mem_addr_d;
  logic [L-1:0]    mem_wdata_q, mem_wdata_d;
  logic            mem_we_q, mem_we_d;
  logic [I*L-1:0]  rdata_v_q, rdata_v_d;
  logic [L-1:0]    rdata_s_q, rdata_s_d;
  logic            err_q, err_d;

  logic [CW-1:0]   last_idx;
  logic [A:0]      end_addr;
  logic            oob;
  logic            issue;

  assign last_idx = op_vec_q ? CW'(I - 1) : '0;

  // One extra bit so a burst that wraps past all-ones counts as out of range.
  assign end_addr = {1'b0, addr_i} + (op_vec_i ? (A+1)'(I) : (A+1)'(1));
  assign oob      = BOUNDS_EN && (end_addr > (A+1)'(MEM_DEPTH));

  always_comb begin
    state_d     = state_q;
    op_vec_d    = op_vec_q;
    wdata_d     = wdata_q;
    idx_d       = idx_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    err_d       = 1'b0;
    issue       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          op_vec_d = op_vec_i;
          wdata_d  = wdata_v_i;
          idx_d    = '0;
          if (oob) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            mem_addr_d = addr_i;
            if (op_we_i) begin
              state_d     = WRITE;
              mem_we_d    = 1'b1;
              mem_wdata_d = op_vec_i ? wdata_v_i[L-1:0] : wdata_s_i;
            end else begin
              state_d = READ;
            end
          end
        end
      end
      WRITE: begin
        if (idx_q == last_idx) begin
          state_d = DONE;
        end else begin
          // Store vector shifts down so the next element is always in the low lane.
          wdata_d     = wdata_q >> L;
          idx_d       = idx_q + 1'b1;
          mem_addr_d  = mem_addr_q + 1'b1;
          mem_we_d    = 1'b1;
          mem_wdata_d = wdata_d[L-1:0];
        end
      end
      READ: begin
        issue = 1'b1;
        if (idx_q == last_idx) begin
          state_d = DRAIN;
        end else begin
          idx_d      = idx_q + 1'b1;
          mem_addr_d = mem_addr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (vld_q[RD_LAT-1] && (cap_idx_q == last_idx)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read-return tracking: a tag per issued address, aged RD_LAT cycles.
  always_comb begin
    vld_d     = RD_LAT'({vld_q, issue});
    cap_idx_d = cap_idx_q;
    rdata_v_d = rdata_v_q;
    rdata_s_d = rdata_s_q;
    if (state_q == IDLE) begin
      cap_idx_d = '0;
    end
    if (vld_q[RD_LAT-1]) begin
      if (op_vec_q) begin
        rdata_v_d[int'(cap_idx_q) * L +: L] = mem_rdata_i;
      end else begin
        rdata_s_d = mem_rdata_i;
      end
      cap_idx_d = cap_idx_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      op_vec_q    <= 1'b0;
      wdata_q     <= '0;
      idx_q       <= '0;
      cap_idx_q   <= '0;
      vld_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      rdata_v_q   <= '0;
      rdata_s_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_vec_q    <= op_vec_d;
      wdata_q     <= wdata_d;
      idx_q       <= idx_d;
      cap_idx_q   <= cap_idx_d;
      vld_q       <= vld_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      rdata_v_q   <= rdata_v_d;
      rdata_s_q   <= rdata_s_d;
      err_q       <= err_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = !req_ready_o;
  assign done_o      = (state_q == DONE);
  assign err_o       = err_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_we_o    = mem_we_q;
  assign rdata_v_o   = rdata_v_q;
  assign rdata_s_o   = rdata_s_q;

endmodule

// File: tb/tb_vec_mem_burst_unit.sv
// Self-checking bench for vec_mem_burst_unit: RAM model plus a byte-array reference
// memory that predicts every bus access, completion cycle and result register.
module tb_vec_mem_burst_unit;

  localparam int I      = 20;
  localparam int L      = 8;
  localparam int A      = 32;
  localparam int RD_LAT = 1;

  logic           CLK = 1'b0;
  logic           RST;
  logic           req_valid_i;
  logic           req_ready_o;
  logic           op_vec_i;
  logic           op_we_i;
  logic [A-1:0]   addr_i;
  logic [I*L-1:0] wdata_v_i;
  logic [L-1:0]   wdata_s_i;
  logic [A-1:0]   mem_addr_o;
  logic [L-1:0]   mem_wdata_o;
  logic           mem_we_o;
  logic [L-1:0]   mem_rdata_i;
  logic [I*L-1:0] rdata_v_o;
  logic [L-1:0]   rdata_s_o;
  logic           done_o;
  logic           busy_o;
  logic           err_o;

  int n_checks = 0;
  int n_fail   = 0;

  vec_mem_burst_unit #(.I(I), .L(L), .A(A), .RD_LAT(RD_LAT), .MEM_DEPTH(4096)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .op_vec_i(op_vec_i), .op_we_i(op_we_i), .addr_i(addr_i),
    .wdata_v_i(wdata_v_i), .wdata_s_i(wdata_s_i),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o),
    .mem_rdata_i(mem_rdata_i),
    .rdata_v_o(rdata_v_o), .rdata_s_o(rdata_s_o),
    .done_o(done_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 CLK = ~CLK;

  // RAM behind the DUT: 4 KiB aliased by the low 12 address bits, RD_LAT read pipeline.
  logic [7:0] ram [4096];
  logic [7:0] rd_pipe [RD_LAT];
  logic       ram_clr;
  always @(posedge CLK) begin
    if (ram_clr) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
    end else if (mem_we_o) begin
      ram[mem_addr_o[11:0]] <= mem_wdata_o;
    end
    rd_pipe[0] <= ram[mem_addr_o[11:0]];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata_i = rd_pipe[RD_LAT-1];

  // Reference model state
  logic [7:0]     gold [4096];
  logic [I*L-1:0] exp_rv;
  logic [L-1:0]   exp_rs;

  // Observations of the last transaction
  logic [31:0] obs_wa[$];
  logic [7:0]  obs_wd[$];
  logic [31:0] obs_ra[$];

  function automatic logic [I*L-1:0] rand_vec();
    logic [I*L-1:0] v;
    for (int w = 0; w < (I*L)/32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_apply(input bit vec, input bit we, input logic [31:0] addr,
                             input logic [I*L-1:0] wv, input logic [7:0] ws);
    int n;
    logic [31:0] a;
    n = vec ? I : 1;
    for (int k = 0; k < n; k++) begin
      a = addr + 32'(k);
      if (we) gold[a[11:0]] = vec ? wv[k*8 +: 8] : ws;
      else if (vec) exp_rv[k*8 +: 8] = gold[a[11:0]];
      else exp_rs = gold[a[11:0]];
    end
  endtask

  // Issues one request from an idle DUT and records the bus until done_o (bounded).
  task automatic xact(input bit vec, input bit we, input logic [31:0] addr,
                      input logic [I*L-1:0] wv, input logic [7:0] ws,
                      output int done_cyc, output bit err_seen);
    obs_wa.delete(); obs_wd.delete(); obs_ra.delete();
    done_cyc = -1;
    err_seen = 1'b0;
    op_vec_i = vec; op_we_i = we; addr_i = addr; wdata_v_i = wv; wdata_s_i = ws;
    req_valid_i = 1'b1;
    @(posedge CLK); #1;
    req_valid_i = 1'b0;
    for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
      @(negedge CLK);
      if (done_o) begin
        done_cyc = c;
        err_seen = err_o;
      end else if (mem_we_o) begin
        obs_wa.push_back(mem_addr_o);
        obs_wd.push_back(mem_wdata_o);
      end else begin
        obs_ra.push_back(mem_addr_o);
      end
    end
    @(posedge CLK); #1;
    $display("xact vec=%0d we=%0d addr=%h done_cycle=%0d writes=%0d", vec, we, addr, done_cyc, obs_wa.size());
  endtask

  task automatic test_reset();
    RST = 1'b1; ram_clr = 1'b1; req_valid_i = 1'b0;
    op_vec_i = 1'b0; op_we_i = 1'b0; addr_i = '0; wdata_v_i = '0; wdata_s_i = '0;
    for (int i = 0; i < 4096; i++) gold[i] = 8'h00;
    exp_rv = '0; exp_rs = '0;
    @(posedge CLK); @(posedge CLK); @(negedge CLK);
    n_checks++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", req_ready_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done_o); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err_o); end
    n_checks++; if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", mem_we_o); end
    n_checks++; if (mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", mem_addr_o); end
    n_checks++; if (mem_wdata_o !== 8'h0) begin n_fail++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata_o); end
    n_checks++; if (rdata_v_o !== '0) begin n_fail++; $display("FAIL reset_rdata_v got=%h exp=0", rdata_v_o); end
    n_checks++; if (rdata_s_o !== 8'h0) begin n_fail++; $display("FAIL reset_rdata_s got=%h exp=0", rdata_s_o); end
    RST = 1'b0; ram_clr = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_scalar_store();
    int dc; bit e;
    model_apply(1'b0, 1'b1, 32'h10, '0, 8'hA5);
    xact(1'b0, 1'b1, 32'h10, '0, 8'hA5, dc, e);
    n_checks++; if (dc !== 2) begin n_fail++; $display("FAIL sstore_done_cycle got=%0d exp=2", dc); end
    n_checks++; if (obs_wa.size() !== 1) begin n_fail++; $display("FAIL sstore_nwrites got=%0d exp=1", obs_wa.size()); end
    if (obs_wa.size() > 0) begin
      n_checks++; if (obs_wa[0] !== 32'h10 || obs_wd[0] !== 8'hA5)
        begin n_fail++; $display("FAIL sstore_bus got=%h/%h exp=00000010/a5", obs_wa[0], obs_wd[0]); end
    end
    n_checks++; if (rdata_s_o !== exp_rs) begin n_fail++; $display("FAIL sstore_rdata_s got=%h exp=%h", rdata_s_o, exp_rs); end
    n_checks++; if (done_o !== 1'b0 || req_ready_o !== 1'b1)
      begin n_fail++; $display("FAIL sstore_after_done got done=%b ready=%b exp done=0 ready=1", done_o, req_ready_o); end
  endtask

  task automatic test_vector_store_load();
    logic [I*L-1:0] wv;
    int dc; bit e;
    for (int k = 0; k < I; k++) wv[k*8 +: 8] = 8'(k + 1);
    model_apply(1'b1, 1'b1, 32'h100, wv, 8'h00);
    xact(1'b1, 1'b1, 32'h100, wv, 8'h00, dc, e);
    n_checks++; if (dc !== I + 1) begin n_fail++; $display("FAIL vstore_done_cycle got=%0d exp=%0d", dc, I + 1); end
    n_checks++; if (obs_wa.size() !== I) begin n_fail++; $display("FAIL vstore_nwrites got=%0d exp=%0d", obs_wa.size(), I); end
    for (int k = 0; k < obs_wa.size() && k < I; k++) begin
      n_checks++;
      if (obs_wa[k] !== 32'h100 + 32'(k) || obs_wd[k] !== 8'(k + 1))
        begin n_fail++; $display("FAIL vstore_elem%0d got=%h/%h exp=%h/%h", k, obs_wa[k], obs_wd[k], 32'h100 + 32'(k), 8'(k + 1)); end
    end
    model_apply(1'b1, 1'b0, 32'h100, '0, 8'h00);
    xact(1'b1, 1'b0, 32'h100, '0, 8'h00, dc, e);
    n_checks++; if (dc !== I + RD_LAT + 1) begin n_fail++; $display("FAIL vload_done_cycle got=%0d exp=%0d", dc, I + RD_LAT + 1); end
    n_checks++; if (rdata_v_o !== wv) begin n_fail++; $display("FAIL vload_rdata_v got=%h exp=%h", rdata_v_o, wv); end
    n_checks++; if (obs_wa.size() !== 0) begin n_fail++; $display("FAIL vload_writes got=%0d exp=0", obs_wa.size()); end
    n_checks++; if (rdata_s_o !== exp_rs) begin n_fail++; $display("FAIL vload_rdata_s got=%h exp=%h", rdata_s_o, exp_rs); end
  endtask

  task automatic test_wrap();
    logic [I*L-1:0] wv;
    logic [31:0] base;
    int dc; bit e;
    base = 32'hFFFF_FFFE;
    wv = rand_vec();
    model_apply(1'b1, 1'b1, base, wv, 8'h00);
    xact(1'b1, 1'b1, base, wv, 8'h00, dc, e);
    n_checks++; if (obs_wa.size() < 4) begin n_fail++; $display("FAIL wrap_nwrites got=%0d exp=%0d", obs_wa.size(), I); end
    else begin
      n_checks++; if (obs_wa[1] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_addr1 got=%h exp=ffffffff", obs_wa[1]); end
      n_checks++; if (obs_wa[2] !== 32'h0) begin n_fail++; $display("FAIL wrap_addr2 got=%h exp=00000000", obs_wa[2]); end
      n_checks++; if (obs_wa[3] !== 32'h1) begin n_fail++; $display("FAIL wrap_addr3 got=%h exp=00000001", obs_wa[3]); end
    end
    model_apply(1'b0, 1'b0, base, '0, 8'h00);
    xact(1'b0, 1'b0, base, '0, 8'h00, dc, e);
    n_checks++; if (dc !== 1 + RD_LAT + 1) begin n_fail++; $display("FAIL wrap_sload_done got=%0d exp=%0d", dc, 2 + RD_LAT); end
    n_checks++; if (rdata_s_o !== exp_rs) begin n_fail++; $display("FAIL wrap_sload_data got=%h exp=%h", rdata_s_o, exp_rs); end
    model_apply(1'b1, 1'b0, base, '0, 8'h00);
    xact(1'b1, 1'b0, base, '0, 8'h00, dc, e);
    n_checks++; if (obs_ra.size() < 3 || obs_ra[2] !== 32'h0)
      begin n_fail++; $display("FAIL wrap_vload_addr2 got=%h exp=00000000", obs_ra.size() > 2 ? obs_ra[2] : 32'hDEAD); end
    n_checks++; if (rdata_v_o !== exp_rv) begin n_fail++; $display("FAIL wrap_vload_data got=%h exp=%h", rdata_v_o, exp_rv); end
  endtask

  task automatic test_random();
    bit vec, we;
    logic [31:0] addr;
    logic [I*L-1:0] wv;
    logic [7:0] ws;
    int n, dc, exp_dc;
    bit e;
    for (int t = 0; t < 24; t++) begin
      vec  = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      wv   = rand_vec();
      ws   = 8'($urandom);
      n    = vec ? I : 1;
      exp_dc = we ? n + 1 : n + RD_LAT + 1;
      model_apply(vec, we, addr, wv, ws);
      xact(vec, we, addr, wv, ws, dc, e);
      n_checks++; if (dc !== exp_dc) begin n_fail++; $display("FAIL rand%0d_done got=%0d exp=%0d", t, dc, exp_dc); end
      n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL rand%0d_err got=%b exp=0", t, e); end
      if (we) begin
        n_checks++; if (obs_wa.size() !== n) begin n_fail++; $display("FAIL rand%0d_nwrites got=%0d exp=%0d", t, obs_wa.size(), n); end
        for (int k = 0; k < obs_wa.size() && k < n; k++) begin
          n_checks++;
          if (obs_wa[k] !== addr + 32'(k) || obs_wd[k] !== (vec ? wv[k*8 +: 8] : ws))
            begin n_fail++; $display("FAIL rand%0d_write%0d got=%h/%h exp=%h/%h", t, k, obs_wa[k], obs_wd[k], addr + 32'(k), vec ? wv[k*8 +: 8] : ws); end
        end
      end else begin
        n_checks++; if (obs_ra.size() < n) begin n_fail++; $display("FAIL rand%0d_nreads got=%0d exp>=%0d", t, obs_ra.size(), n); end
        for (int k = 0; k < obs_ra.size() && k < n; k++) begin
          n_checks++; if (obs_ra[k] !== addr + 32'(k))
            begin n_fail++; $display("FAIL rand%0d_raddr%0d got=%h exp=%h", t, k, obs_ra[k], addr + 32'(k)); end
        end
      end
      n_checks++; if (rdata_v_o !== exp_rv) begin n_fail++; $display("FAIL rand%0d_rdata_v got=%h exp=%h", t, rdata_v_o, exp_rv); end
      n_checks++; if (rdata_s_o !== exp_rs) begin n_fail++; $display("FAIL rand%0d_rdata_s got=%h exp=%h", t, rdata_s_o, exp_rs); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [I*L-1:0] wv;
    int done_a, done_b, acc_cnt, acc_cyc, done_cnt;
    a = 32'h0000_0200;
    wv = rand_vec();
    done_a = -1; done_b = -1; acc_cnt = 0; acc_cyc = -1; done_cnt = 0;
    model_apply(1'b1, 1'b1, a, wv, 8'h00);
    model_apply(1'b0, 1'b0, a + 32'd5, '0, 8'h00);
    op_vec_i = 1'b1; op_we_i = 1'b1; addr_i = a; wdata_v_i = wv; req_valid_i = 1'b1;
    @(posedge CLK); #1;
    op_vec_i = 1'b0; op_we_i = 1'b0; addr_i = a + 32'd5;
    for (int c = 1; c <= 40; c++) begin
      @(negedge CLK);
      if (done_o) begin
        done_cnt++;
        if (done_a < 0) done_a = c; else done_b = c;
      end
      if (req_valid_i && req_ready_o) begin acc_cnt++; acc_cyc = c; end
      @(posedge CLK); #1;
      if (acc_cyc == c) req_valid_i = 1'b0;
    end
    $display("xact back_to_back doneA=%0d accept=%0d doneB=%0d", done_a, acc_cyc, done_b);
    n_checks++; if (done_a !== I + 1) begin n_fail++; $display("FAIL b2b_doneA got=%0d exp=%0d", done_a, I + 1); end
    n_checks++; if (acc_cnt !== 1) begin n_fail++; $display("FAIL b2b_accepts got=%0d exp=1", acc_cnt); end
    n_checks++; if (acc_cyc !== I + 2) begin n_fail++; $display("FAIL b2b_accept_cycle got=%0d exp=%0d", acc_cyc, I + 2); end
    n_checks++; if (done_b !== I + 2 + 1 + RD_LAT + 1) begin n_fail++; $display("FAIL b2b_doneB got=%0d exp=%0d", done_b, I + 4 + RD_LAT); end
    n_checks++; if (done_cnt !== 2) begin n_fail++; $display("FAIL b2b_done_pulses got=%0d exp=2", done_cnt); end
    n_checks++; if (rdata_s_o !== exp_rs) begin n_fail++; $display("FAIL b2b_rdata_s got=%h exp=%h", rdata_s_o, exp_rs); end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] base;
    logic [I*L-1:0] wv;
    logic [7:0] old7;
    int dc; bit e; bit saw_done;
    base = 32'h0000_0400;
    wv = rand_vec();
    saw_done = 1'b0;
    old7 = gold[12'(base + 32'd7)];
    op_vec_i = 1'b1; op_we_i = 1'b1; addr_i = base; wdata_v_i = wv; req_valid_i = 1'b1;
    @(posedge CLK); #1;
    req_valid_i = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      if (done_o) saw_done = 1'b1;
    end
    n_checks++; if (mem_we_o !== 1'b1 || mem_addr_o !== base + 32'd7)
      begin n_fail++; $display("FAIL rst_mid_elem7 got we=%b addr=%h exp we=1 addr=%h", mem_we_o, mem_addr_o, base + 32'd7); end
    RST = 1'b1;
    #1;
    n_checks++; if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_we got=%b exp=0", mem_we_o); end
    n_checks++; if (req_ready_o !== 1'b1 || busy_o !== 1'b0)
      begin n_fail++; $display("FAIL rst_mid_ready got ready=%b busy=%b exp ready=1 busy=0", req_ready_o, busy_o); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done got=%b exp=0", done_o); end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge CLK);
      if (done_o) saw_done = 1'b1;
    end
    n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_done got=%b exp=0", saw_done); end
    $display("xact reset_mid_burst addr=%h", base);
    for (int k = 0; k < 7; k++) gold[12'(base + 32'(k))] = wv[k*8 +: 8];
    exp_rv = '0; exp_rs = '0;
    @(posedge CLK); #1;
    model_apply(1'b0, 1'b0, base + 32'd6, '0, 8'h00);
    xact(1'b0, 1'b0, base + 32'd6, '0, 8'h00, dc, e);
    n_checks++; if (dc !== 2 + RD_LAT) begin n_fail++; $display("FAIL rst_after_done got=%0d exp=%0d", dc, 2 + RD_LAT); end
    n_checks++; if (rdata_s_o !== wv[6*8 +: 8]) begin n_fail++; $display("FAIL rst_after_elem6 got=%h exp=%h", rdata_s_o, wv[6*8 +: 8]); end
    model_apply(1'b0, 1'b0, base + 32'd7, '0, 8'h00);
    xact(1'b0, 1'b0, base + 32'd7, '0, 8'h00, dc, e);
    n_checks++; if (rdata_s_o !== old7) begin n_fail++; $display("FAIL rst_elem7_unwritten got=%h exp=%h", rdata_s_o, old7); end
    n_checks++; if (rdata_v_o !== exp_rv) begin n_fail++; $display("FAIL rst_rdata_v_cleared got=%h exp=%h", rdata_v_o, exp_rv); end
  endtask

  initial begin
    test_reset();
    test_scalar_store();
    test_vector_store_load();
    test_wrap();
    test_random();
    test_back_to_back();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vec_mem_burst_unit.md
Name: vec_mem_burst_unit

Overview:
- Data-memory sequencer downstream of the CPU memory stage.
- Turns one scalar or vector (I-element) load/store request into a burst of byte-wide accesses on a single-port synchronous RAM.
- Assembles load data into a packed vector or scalar, then pulses done back to the pipeline.
- Single outstanding request; the pipeline stalls on busy_o.

Parameters:
- I, 20, elements per vector access
- L, 8, element/RAM data width in bits
- A, 32, address width
- RD_LAT, 1, RAM read latency in cycles (1..3)
- MEM_DEPTH, 4096, RAM depth in elements (used only by the optional feature)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  request present
- req_ready_o  out  1  unit can accept a request
- op_vec_i  in  1  1=vector (I elements), 0=scalar (1 element)
- op_we_i  in  1  1=store, 0=load
- addr_i  in  A  base element address
- wdata_v_i  in  I*L  store vector; element k at [k*L+L-1:k*L]
- wdata_s_i  in  L  store scalar
- mem_addr_o  out  A  RAM address
- mem_wdata_o  out  L  RAM write data
- mem_we_o  out  1  RAM write enable
- mem_rdata_i  in  L  RAM read data, valid RD_LAT cycles after its address
- rdata_v_o  out  I*L  loaded vector
- rdata_s_o  out  L  loaded scalar
- done_o  out  1  one-cycle completion pulse
- busy_o  out  1  request in progress
- err_o  out  1  one-cycle error pulse; tied 0 unless the optional feature is enabled

Behaviour:
- Reset: state IDLE; all outputs 0 except req_ready_o=1. mem_we_o drops asynchronously. Reset mid-burst abandons the burst with no done_o.
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- Accept: at a rising edge with req_valid_i && req_ready_o. All request fields are latched into internal registers. req_ready_o = (state==IDLE). Requests while busy are ignored, not queued.
- Count n: n = I if op_vec_i, else 1. Element k (0..n-1) uses address addr_i+k, computed modulo 2^A (wraps at all-ones).
- WRITE:
  - In cycle k+1 after accept: mem_we_o=1, mem_addr_o=addr+k, mem_wdata_o=element k (scalar: wdata_s_i).
  - After the last element go to DONE. done_o=1 in cycle n+1.
  - Vector store: done at cycle 21. Scalar store: done at cycle 2.
- READ:
  - In cycle k+1: mem_we_o=0, mem_addr_o=addr+k.
  - After the last address go to DRAIN for RD_LAT cycles.
  - Element k is captured from mem_rdata_i at the edge closing cycle k+1+RD_LAT. Use a shift register of valid tags plus an index counter.
  - done_o=1 in cycle n+RD_LAT+1.
  - Vector load, RD_LAT=1: done at cycle 22. Scalar load: done at cycle 3.
- DONE: lasts one cycle (done_o=1, busy_o=1), then IDLE. A new request can be accepted the cycle after done_o.
- Idle bus: mem_addr_o and mem_wdata_o hold their last value; mem_we_o=0.
- Result registers:
  - rdata_v_o updates only on vector loads; rdata_s_o updates only on scalar loads.
  - Both hold until the next load of their kind. Stores never modify them.
  - Elements of rdata_v_o are written in place as captured; the full vector is valid when done_o=1.
- busy_o = !req_ready_o.

Optional Feature:
- Macro: VMEM_BOUNDS_CHECK_EN.
- Defined:
  - On accept, if addr_i+n > MEM_DEPTH (computed in A+1 bits, so wrap counts as out of bounds), go straight to DONE.
  - That cycle asserts done_o=1 and err_o=1, with no RAM access and result registers unchanged.
- Undefined: no check; err_o tied 0; accesses wrap modulo 2^A.

Test Plan:
- Scalar store: addr=0x10, wdata_s=0xA5 -> cycle 1 shows mem_we_o=1, addr 0x10, data 0xA5; done_o in cycle 2; rdata_s_o unchanged.
- Vector store then vector load: store element k=k+1 at addr 0x100, then load addr 0x100 (RD_LAT=1) -> 20 writes at 0x100..0x113; load done_o at cycle 22; rdata_v_o byte k = k+1.
- Wrap-around: scalar then vector load at addr 0xFFFF_FFFE -> addresses FFFF_FFFE, FFFF_FFFF, 0, 1, ... (macro undefined).
- Back-to-back and busy: hold req_valid_i high with a second request during a burst -> second request accepted only the cycle after done_o; never lost, never duplicated.
- Reset mid-burst: assert RST at vector-store element 7 -> mem_we_o=0 immediately, req_ready_o=1, no done_o; a following scalar load completes normally.
- VMEM_BOUNDS_CHECK_EN defined, MEM_DEPTH=4096, vector load at addr 4090 -> done_o and err_o together in cycle 1; mem_we_o=0; rdata_v_o unchanged.
